// File: rtl/sat_chan_ctrl.sv
// Satellite channel controller: sample-strobe divider, strobe counter and
// per-channel shadow/active configuration with strobe-aligned atomic commit.
module sat_chan_ctrl #(
  parameter int NCHAN = 6,
  parameter int DECIM = 64
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  enable,
  input  logic                  cfg_we,
  input  logic [4:0]            cfg_addr,
  input  logic [31:0]           cfg_wdata,
  input  logic                  commit,
  output logic                  commit_busy,
  output logic                  commit_done,
  output logic                  dv_out,
  output logic [31:0]           stb_count,
  output logic [NCHAN*32-1:0]   code_freq,
  output logic [NCHAN*32-1:0]   dop_freq,
  output logic [NCHAN*16-1:0]   gain,
  output logic [NCHAN*6-1:0]    ca_sel,
  output logic [NCHAN-1:0]      chan_en
);

  // state | meaning
  // IDLE  | no commit outstanding
  // PEND  | commit requested, shadow copied to active on next strobe edge
  typedef enum logic {IDLE, PEND} state_t;

  localparam int CW = (DECIM > 2) ? $clog2(DECIM) : 1;
  localparam logic [CW-1:0] LAST = CW'(DECIM - 1);

  state_t        state, state_nxt;
  logic          copy;
  logic [CW-1:0] div_cnt;
  logic [2:0]    wr_ch;
  logic          wr_ok;

  logic [31:0] sh_code [NCHAN];
  logic [31:0] sh_dop  [NCHAN];
  logic [15:0] sh_gain [NCHAN];
  logic [5:0]  sh_ca   [NCHAN];
  logic        sh_en   [NCHAN];

  logic [31:0] act_code [NCHAN];
  logic [31:0] act_dop  [NCHAN];
  logic [15:0] act_gain [NCHAN];
  logic [5:0]  act_ca   [NCHAN];
  logic        act_en   [NCHAN];

  assign dv_out = enable && (div_cnt == LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_cnt   <= '0;
      stb_count <= '0;
    end else begin
      if (!enable || dv_out) div_cnt <= '0;
      else                   div_cnt <= div_cnt + 1'b1;
      if (dv_out) stb_count <= stb_count + 32'd1;
    end
  end

  assign wr_ch = cfg_addr[4:2];
  assign wr_ok = cfg_we && (int'(wr_ch) < NCHAN);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < NCHAN; k++) begin
        sh_code[k] <= '0;
        sh_dop[k]  <= '0;
        sh_gain[k] <= '0;
        sh_ca[k]   <= '0;
        sh_en[k]   <= 1'b0;
      end
    end else if (wr_ok) begin
      case (cfg_addr[1:0])
        2'd0: sh_code[wr_ch] <= cfg_wdata;
        2'd1: sh_dop[wr_ch]  <= cfg_wdata;
        2'd2: sh_gain[wr_ch] <= cfg_wdata[15:0];
        default: begin
          sh_ca[wr_ch] <= cfg_wdata[5:0];
          sh_en[wr_ch] <= cfg_wdata[8];
        end
      endcase
    end
  end

  // Copy samples shadow before any same-edge write lands.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < NCHAN; k++) begin
        act_code[k] <= '0;
        act_dop[k]  <= '0;
        act_gain[k] <= '0;
        act_ca[k]   <= '0;
        act_en[k]   <= 1'b0;
      end
    end else if (copy) begin
      for (int k = 0; k < NCHAN; k++) begin
        act_code[k] <= sh_code[k];
        act_dop[k]  <= sh_dop[k];
        act_gain[k] <= sh_gain[k];
        act_ca[k]   <= sh_ca[k];
        act_en[k]   <= sh_en[k];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      commit_done <= 1'b0;
    end else begin
      state       <= state_nxt;
      commit_done <= copy;
    end
  end

  always_comb begin
    state_nxt = state;
    copy      = 1'b0;
    case (state)
      IDLE: begin
        if (commit) begin
          if (enable) state_nxt = PEND;
          else        copy      = 1'b1;
        end
      end
      PEND: begin
        if (dv_out) begin
          copy      = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign commit_busy = (state == PEND);

  for (genvar k = 0; k < NCHAN; k++) begin : g_pack
    assign code_freq[32*k +: 32] = act_code[k];
    assign dop_freq[32*k +: 32]  = act_dop[k];
    assign gain[16*k +: 16]      = act_gain[k];
    assign ca_sel[6*k +: 6]      = act_ca[k];
    assign chan_en[k]            = act_en[k];
  end

endmodule

// File: tb/tb_sat_chan_ctrl.sv
// Scoreboard bench for sat_chan_ctrl: commits push expected active snapshots,
// a negedge monitor checks strobes, counts, busy/done timing and active values.
module tb_sat_chan_ctrl;
  localparam int NCHAN = 6;
  localparam int DECIM = 64;

  logic clk, reset_n, enable, cfg_we, commit;
  logic [4:0]  cfg_addr;
  logic [31:0] cfg_wdata;
  logic commit_busy, commit_done, dv_out;
  logic [31:0] stb_count;
  logic [NCHAN*32-1:0] code_freq, dop_freq;
  logic [NCHAN*16-1:0] gain;
  logic [NCHAN*6-1:0]  ca_sel;
  logic [NCHAN-1:0]    chan_en;

  sat_chan_ctrl #(.NCHAN(NCHAN), .DECIM(DECIM)) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .cfg_we(cfg_we),
    .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata), .commit(commit),
    .commit_busy(commit_busy), .commit_done(commit_done), .dv_out(dv_out),
    .stb_count(stb_count), .code_freq(code_freq), .dop_freq(dop_freq),
    .gain(gain), .ca_sel(ca_sel), .chan_en(chan_en)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  task automatic chk(input bit ok, input string name, input string act, input string exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %s expected %s (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    logic [NCHAN*32-1:0] code;
    logic [NCHAN*32-1:0] dop;
    logic [NCHAN*16-1:0] gain;
    logic [NCHAN*6-1:0]  ca;
    logic [NCHAN-1:0]    en;
    int                  issue;
    bit                  imm;
  } rec_t;

  rec_t sb[$];
  rec_t act;

  logic [31:0] s_code [NCHAN];
  logic [31:0] s_dop  [NCHAN];
  logic [15:0] s_gain [NCHAN];
  logic [5:0]  s_ca   [NCHAN];
  logic        s_en   [NCHAN];

  function automatic rec_t snap();
    rec_t r;
    for (int k = 0; k < NCHAN; k++) begin
      r.code[32*k +: 32] = s_code[k];
      r.dop[32*k +: 32]  = s_dop[k];
      r.gain[16*k +: 16] = s_gain[k];
      r.ca[6*k +: 6]     = s_ca[k];
      r.en[k]            = s_en[k];
    end
    r.issue = 0;
    r.imm   = 1'b0;
    return r;
  endfunction

  task automatic clear_shadow();
    for (int k = 0; k < NCHAN; k++) begin
      s_code[k] = '0; s_dop[k] = '0; s_gain[k] = '0; s_ca[k] = '0; s_en[k] = 1'b0;
    end
  endtask

  // Monitor: expected strobe = every DECIM-th consecutive enabled cycle.
  int  run = 0;
  int  exp_cnt = 0;
  bit  prev_dv = 0;
  always @(negedge clk) begin
    bit exp_dv, exp_done, exp_busy;
    if (!reset_n) begin
      run = 0; exp_cnt = 0; prev_dv = 0;
      sb.delete();
      act = '{default: '0};
      chk(dv_out == 1'b0 && commit_done == 1'b0 && commit_busy == 1'b0, "reset_ctrl",
          $sformatf("dv=%b done=%b busy=%b", dv_out, commit_done, commit_busy), "all 0");
      chk(stb_count == 32'd0, "reset_stb_count", $sformatf("%0d", stb_count), "0");
    end else begin
      run = enable ? run + 1 : 0;
      exp_dv = enable && (run % DECIM == 0);
      chk(dv_out == exp_dv, "dv_out", $sformatf("%b", dv_out), $sformatf("%b", exp_dv));
      chk(stb_count == 32'(exp_cnt), "stb_count", $sformatf("%0d", stb_count), $sformatf("%0d", exp_cnt));
      exp_done = 1'b0;
      if (sb.size() > 0) begin
        if (sb[0].imm) exp_done = (cyc == sb[0].issue + 1);
        else           exp_done = prev_dv && (cyc - 1 > sb[0].issue);
      end
      chk(commit_done == exp_done, "commit_done", $sformatf("%b", commit_done), $sformatf("%b", exp_done));
      if ((exp_done || commit_done) && sb.size() > 0) act = sb.pop_front();
      exp_busy = (sb.size() > 0) && !sb[0].imm && (cyc > sb[0].issue);
      chk(commit_busy == exp_busy, "commit_busy", $sformatf("%b", commit_busy), $sformatf("%b", exp_busy));
      if (exp_dv) exp_cnt++;
      prev_dv = exp_dv;
    end
    chk(code_freq == act.code, "code_freq", $sformatf("%h", code_freq), $sformatf("%h", act.code));
    chk(dop_freq == act.dop, "dop_freq", $sformatf("%h", dop_freq), $sformatf("%h", act.dop));
    chk(gain == act.gain, "gain", $sformatf("%h", gain), $sformatf("%h", act.gain));
    chk(ca_sel == act.ca && chan_en == act.en, "ca_sel_en",
        $sformatf("%h/%b", ca_sel, chan_en), $sformatf("%h/%b", act.ca, act.en));
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic model_wr(input int ch, input int fld, input logic [31:0] d);
    if (ch < NCHAN) begin
      case (fld)
        0: s_code[ch] = d;
        1: s_dop[ch]  = d;
        2: s_gain[ch] = d[15:0];
        default: begin s_ca[ch] = d[5:0]; s_en[ch] = d[8]; end
      endcase
    end
  endtask

  task automatic do_wr(input int ch, input int fld, input logic [31:0] d);
    cfg_we = 1'b1; cfg_addr = {ch[2:0], fld[1:0]}; cfg_wdata = d;
    tick();
    cfg_we = 1'b0;
    model_wr(ch, fld, d);
  endtask

  task automatic do_commit(input bit accept);
    rec_t r;
    r = snap();
    r.issue = cyc;
    r.imm = !enable;
    if (accept) sb.push_back(r);
    commit = 1'b1;
    tick();
    commit = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string name);
    int n = 0;
    while (sb.size() > 0 && n < budget) begin
      @(negedge clk); n++;
    end
    chk(sb.size() == 0, name, $sformatf("pending=%0d after %0d cycles", sb.size(), n), "pending=0");
    tick();
  endtask

  initial begin
    int c0, nstb;
    bit found;
    reset_n = 1'b0; enable = 1'b0; cfg_we = 1'b0; commit = 1'b0;
    cfg_addr = '0; cfg_wdata = '0;
    clear_shadow();
    repeat (3) tick();

    // Strobes at cycles 63/127/191 after release with enable held high.
    reset_n = 1'b1; enable = 1'b1;
    c0 = cyc; nstb = 0;
    for (int i = 0; i < 300 && nstb < 3; i++) begin
      @(negedge clk);
      if (dv_out) nstb++;
    end
    chk(nstb == 3 && (cyc - c0) == 191, "third_strobe_cycle",
        $sformatf("n=%0d cyc=%0d", nstb, cyc - c0), "n=3 cyc=191");
    tick();
    chk(stb_count == 32'd3, "stb_after_three", $sformatf("%0d", stb_count), "3");

    repeat (20) tick();
    do_wr(2, 0, 32'h12345678);
    do_wr(2, 1, 32'h01234567);
    do_wr(2, 2, 32'h00008000);
    do_wr(2, 3, 32'h00000105);
    do_commit(1'b1);
    wait_done(3 * DECIM, "commit_ch2");
    chk(ca_sel[17:12] == 6'd5 && chan_en[2] == 1'b1, "ch2_ca_en",
        $sformatf("%0d/%b", ca_sel[17:12], chan_en[2]), "5/1");

    do_wr(7, 0, 32'hDEADBEEF);
    do_wr(7, 2, 32'h0000ABCD);
    do_wr(6, 3, 32'h000001FF);
    do_commit(1'b1);
    wait_done(3 * DECIM, "commit_ch7");

    // Write landing on the copy edge goes to shadow only.
    do_wr(0, 2, 32'h00002222);
    do_commit(1'b1);
    found = 1'b0;
    for (int i = 0; i < 3 * DECIM && !found; i++) begin
      @(negedge clk);
      if (dv_out) found = 1'b1;
    end
    chk(found, "copy_edge_strobe", $sformatf("%b", found), "1");
    cfg_we = 1'b1; cfg_addr = {3'd0, 2'd2}; cfg_wdata = 32'h00001111;
    @(posedge clk); #1;
    cfg_we = 1'b0;
    model_wr(0, 2, 32'h00001111);
    wait_done(4, "commit_copy_edge");
    chk(gain[15:0] == 16'h2222, "gain0_old", $sformatf("%h", gain[15:0]), "2222");

    // Immediate commit while disabled.
    enable = 1'b0;
    tick();
    do_commit(1'b1);
    wait_done(4, "commit_disabled");
    chk(gain[15:0] == 16'h1111, "gain0_new", $sformatf("%h", gain[15:0]), "1111");

    // Second commit while pending is ignored; enable dropout keeps it pending.
    enable = 1'b1;
    do_wr(3, 0, 32'hCAFEF00D);
    do_commit(1'b1);
    repeat (5) tick();
    do_commit(1'b0);
    enable = 1'b0;
    repeat (10) tick();
    do_commit(1'b0);
    enable = 1'b1;
    wait_done(3 * DECIM, "commit_ignored");
    repeat (DECIM + 5) tick();

    for (int it = 0; it < 30; it++) begin
      int nw;
      nw = $urandom_range(0, 4);
      for (int w = 0; w < nw; w++)
        do_wr($urandom_range(0, 7), $urandom_range(0, 3), $urandom);
      enable = $urandom_range(0, 3) != 0;
      repeat ($urandom_range(0, 40)) tick();
      do_commit(1'b1);
      wait_done(3 * DECIM, "commit_random");
    end

    // Reset during pending abandons the commit.
    enable = 1'b1;
    do_wr(1, 2, 32'h00007FFF);
    do_commit(1'b1);
    repeat (5) tick();
    reset_n = 1'b0;
    clear_shadow();
    tick();
    reset_n = 1'b1;
    repeat (2 * DECIM + 4) tick();
    chk(gain[31:16] == 16'h0000, "gain1_after_reset", $sformatf("%h", gain[31:16]), "0000");
    chk(sb.size() == 0, "scoreboard_empty", $sformatf("%0d", sb.size()), "0");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/sat_chan_ctrl.md
SAT_CHAN_CTRL -- requirements
Module: sat_chan_ctrl

Interface
REQ-001 Parameter NCHAN, default 6, number of satellite channels configured (1..8).
REQ-002 Parameter DECIM, default 64, clocks per sample strobe (>=2).
REQ-003 clk  input  1  system clock, all logic rising-edge.
REQ-004 reset_n  input  1  reset, asynchronous and active-low.
REQ-005 enable  input  1  run strobe generator; low = held idle.
REQ-006 cfg_we  input  1  shadow register write strobe.
REQ-007 cfg_addr  input  5  [4:2] channel index, [1:0] field: 0 code_freq, 1 dop_freq, 2 gain, 3 ca_sel/en.
REQ-008 cfg_wdata  input  32  write data; field 2 uses [15:0], field 3 uses [5:0] ca_sel and [8] chan_en.
REQ-009 commit  input  1  one-cycle request to apply all shadow registers atomically.
REQ-010 commit_busy  output  1  high while a commit is pending.
REQ-011 commit_done  output  1  one-cycle pulse in the first cycle new active values are visible.
REQ-012 dv_out  output  1  sample strobe to all channels (channel dv_in).
REQ-013 stb_count  output  32  count of strobes issued, wraps at 2^32.
REQ-014 code_freq  output  NCHAN*32  active code NCO increments, channel k at [32k+31:32k].
REQ-015 dop_freq  output  NCHAN*32  active Doppler NCO increments, same packing.
REQ-016 gain  output  NCHAN*16  active channel gains.
REQ-017 ca_sel  output  NCHAN*6  active C/A code selects.
REQ-018 chan_en  output  NCHAN  active channel enables.

Function
REQ-019 Divider counter 0..DECIM-1 shall increment each cycle while enable=1; dv_out=1 exactly in cycles where counter=DECIM-1, then counter wraps to 0.
REQ-020 enable=0 shall hold counter at 0 and dv_out at 0; first strobe after enable rises comes DECIM cycles later.
REQ-021 stb_count shall increment by 1 on every clock edge where dv_out=1.
REQ-022 cfg_we=1 shall write cfg_wdata into the addressed shadow field on that edge; channel index >= NCHAN shall be ignored with no side effect.
REQ-023 Shadow writes shall never alter active outputs directly.
REQ-024 Commit FSM states: IDLE, PEND.
REQ-025 IDLE: commit=1 with enable=1 -> PEND; commit=1 with enable=0 -> copy shadow to active on that edge, commit_done=1 next cycle, stay IDLE.
REQ-026 PEND: on the edge ending a cycle with dv_out=1, copy all shadow fields to active, -> IDLE; commit_done=1 the following cycle.
REQ-027 Updates shall therefore only appear in the cycle after a strobe, never between strobe and the cycle before the next.
REQ-028 commit=1 while in PEND shall be ignored (single pending commit).
REQ-029 enable falling while PEND shall keep PEND; copy occurs on the first strobe after enable returns.
REQ-030 cfg_we and copy on the same edge: the copy shall use the shadow value before that write; the write lands in shadow only.
REQ-031 commit_busy=1 iff state=PEND.
REQ-032 All writes full-width; no arithmetic saturation; unused cfg_wdata bits discarded.

Reset
REQ-033 reset_n=0 shall immediately clear divider, stb_count, all shadow and active registers, dv_out, commit_done, and force IDLE.
REQ-034 Reset asserted mid-PEND shall abandon the commit; no commit_done after release.

Verification
REQ-035 enable=1 from reset release, DECIM=64 -> dv_out pulses at cycles 63, 127, 191; stb_count=3 after third.
REQ-036 Write ch2 code_freq=0x12345678, dop_freq=0x01234567, gain=0x8000, field3=0x105, commit mid-period -> commit_busy high until strobe, ch2 outputs update cycle after strobe, commit_done one pulse, ca_sel=5, chan_en=1.
REQ-037 Write to cfg_addr channel 7 with NCHAN=6, commit -> all active outputs unchanged, commit_done still pulses.
REQ-038 cfg_we ch0 gain=0x1111 on copy edge with shadow 0x2222 -> active gain0=0x2222, shadow retains 0x1111 for next commit.
REQ-039 enable=0, commit -> active updated, commit_done next cycle, dv_out stays 0.
REQ-040 reset_n low for one cycle while PEND with gain ch1=0x7FFF shadowed -> all outputs 0, no commit_done, gain1=0 after strobes resume.
